demulti_latch: RTL and testbench

DEMULTI_LATCH -- requirements
Module: demulti_latch

---
 rtl/demulti_latch_if.sv | 27 ++
 rtl/demulti_latch.sv | 125 ++++++++++++
 tb/tb_demulti_latch.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demulti_latch_if.sv
// Write/clear request channel into the demulti_latch entry bank.
interface demulti_latch_if #(
    parameter int SEL_WID  = 4,
    parameter int DATA_WID = 32
) ();
    logic [SEL_WID-1:0]  sel;
    logic [DATA_WID-1:0] din;
    logic                wr_valid;
    logic                wr_ready;
    logic                clr_all;

    modport master (
        output sel,
        output din,
        output wr_valid,
        output clr_all,
        input  wr_ready
    );

    modport slave (
        input  sel,
        input  din,
        input  wr_valid,
        input  clr_all,
        output wr_ready
    );
endinterface

// File: rtl/demulti_latch.sv
// Sixteen-entry registered demultiplexer: single writes land in out[sel], and a
// clr_all request walks a counter through the entries zeroing one per cycle.
module demulti_latch #(
    parameter int SEL_WID  = 4,
    parameter int DATA_WID = 32
) (
    input  logic                clk,
    input  logic                rst,
    demulti_latch_if.slave      wr_if,
    output logic [DATA_WID-1:0] out0,
    output logic [DATA_WID-1:0] out1,
    output logic [DATA_WID-1:0] out2,
    output logic [DATA_WID-1:0] out3,
    output logic [DATA_WID-1:0] out4,
    output logic [DATA_WID-1:0] out5,
    output logic [DATA_WID-1:0] out6,
    output logic [DATA_WID-1:0] out7,
    output logic [DATA_WID-1:0] out8,
    output logic [DATA_WID-1:0] out9,
    output logic [DATA_WID-1:0] out10,
    output logic [DATA_WID-1:0] out11,
    output logic [DATA_WID-1:0] out12,
    output logic [DATA_WID-1:0] out13,
    output logic [DATA_WID-1:0] out14,
    output logic [DATA_WID-1:0] out15,
    output logic [15:0]         out_upd,
    output logic                busy
);
    localparam int N_ENT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_WID-1:0]  cnt_q, cnt_d;
    logic [DATA_WID-1:0] data_q [N_ENT];
    logic [DATA_WID-1:0] data_d [N_ENT];
    logic [15:0]         upd_q, upd_d;
    logic                wr_ready;
    logic                wr_fire;

    // A clear request blocks writes in the same cycle so the two never collide.
    assign wr_ready       = (state_q == IDLE) && !wr_if.clr_all && !rst;
    assign wr_if.wr_ready = wr_ready;
    assign wr_fire        = wr_if.wr_valid && wr_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        upd_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (wr_if.clr_all) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (wr_fire) begin
                    data_d[wr_if.sel] = wr_if.din;
                    upd_d[wr_if.sel]  = 1'b1;
                end
            end

            CLEAR: begin
                data_d[cnt_q] = '0;
                upd_d[cnt_q]  = 1'b1;
                if (cnt_q == SEL_WID'(N_ENT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SEL_WID'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            upd_q   <= '0;
            // NOTE: the entry array is reset because its contents are visible
            // outputs that must read zero after reset, not scratch storage.
            for (int i = 0; i < N_ENT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
            for (int i = 0; i < N_ENT; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign busy    = (state_q == CLEAR);
    assign out_upd = upd_q;

    assign out0  = data_q[0];
    assign out1  = data_q[1];
    assign out2  = data_q[2];
    assign out3  = data_q[3];
    assign out4  = data_q[4];
    assign out5  = data_q[5];
    assign out6  = data_q[6];
    assign out7  = data_q[7];
    assign out8  = data_q[8];
    assign out9  = data_q[9];
    assign out10 = data_q[10];
    assign out11 = data_q[11];
    assign out12 = data_q[12];
    assign out13 = data_q[13];
    assign out14 = data_q[14];
    assign out15 = data_q[15];
endmodule

// File: tb/tb_demulti_latch.sv
// Directed bench for demulti_latch: writes, back-to-back, sequential clear,
// clear-vs-write priority and reset abort, each against hand-computed values.
module tb_demulti_latch;
    logic        clk;
    logic        rst;
    logic [31:0] o [16];
    logic [15:0] out_upd;
    logic        busy;
    logic [31:0] exp_q [16];
    int          checks;
    int          errors;

    demulti_latch_if #(.SEL_WID(4), .DATA_WID(32)) wif ();

    demulti_latch #(.SEL_WID(4), .DATA_WID(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_if   (wif.slave),
        .out0    (o[0]),
        .out1    (o[1]),
        .out2    (o[2]),
        .out3    (o[3]),
        .out4    (o[4]),
        .out5    (o[5]),
        .out6    (o[6]),
        .out7    (o[7]),
        .out8    (o[8]),
        .out9    (o[9]),
        .out10   (o[10]),
        .out11   (o[11]),
        .out12   (o[12]),
        .out13   (o[13]),
        .out14   (o[14]),
        .out15   (o[15]),
        .out_upd (out_upd),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (wif.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_ready got %b want 0", wif.wr_ready);
        end
        checks++;
        if (busy !== 1'b0 || out_upd !== 16'h0) begin
            errors++;
            $display("FAIL reset_busy_upd got busy=%b upd=%h want 0/0000", busy, out_upd);
        end
        for (int i = 0; i < 16; i++) begin
            exp_q[i] = 32'h0;
            checks++;
            if (o[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_out%0d got %h want 00000000", i, o[i]);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (wif.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_wr_ready got %b want 1", wif.wr_ready);
        end
    endtask

    task automatic test_single_write();
        wif.sel      = 4'd5;
        wif.din      = 32'hDEADBEEF;
        wif.wr_valid = 1'b1;
        step();
        wif.wr_valid = 1'b0;
        exp_q[5] = 32'hDEADBEEF;
        checks++;
        if (out_upd !== 16'h0020) begin
            errors++;
            $display("FAIL single_upd got %h want 0020", out_upd);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (o[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_out%0d got %h want %h", i, o[i], exp_q[i]);
            end
        end
        step();
        checks++;
        if (out_upd !== 16'h0) begin
            errors++;
            $display("FAIL single_upd_idle got %h want 0000", out_upd);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            wif.sel      = 4'(i);
            wif.din      = 32'h100 + 32'(i);
            wif.wr_valid = 1'b1;
            step();
            exp_q[i] = 32'h100 + 32'(i);
            checks++;
            if (out_upd !== (16'h1 << i) || o[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_step%0d got upd=%h out=%h want upd=%h out=%h",
                         i, out_upd, o[i], 16'h1 << i, exp_q[i]);
            end
        end
        wif.sel = 4'd2;
        wif.din = 32'hA;
        step();
        wif.din = 32'hB;
        step();
        wif.wr_valid = 1'b0;
        exp_q[2] = 32'hB;
        step();
        checks++;
        if (out_upd !== 16'h0) begin
            errors++;
            $display("FAIL b2b_upd_idle got %h want 0000", out_upd);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (o[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_out%0d got %h want %h", i, o[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clear();
        wif.clr_all = 1'b1;
        #1;
        checks++;
        if (wif.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_req_wr_ready got %b want 0", wif.wr_ready);
        end
        step();
        wif.clr_all = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_upd !== 16'h0) begin
            errors++;
            $display("FAIL clear_enter got busy=%b upd=%h want 1/0000", busy, out_upd);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (busy !== 1'b1 || wif.wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear_busy%0d got busy=%b rdy=%b want 1/0", k, busy, wif.wr_ready);
            end
            if (k == 4) begin
                wif.sel      = 4'd7;
                wif.din      = 32'h77;
                wif.wr_valid = 1'b1;
                wif.clr_all  = 1'b1;
            end
            step();
            wif.wr_valid = 1'b0;
            wif.clr_all  = 1'b0;
            exp_q[k] = 32'h0;
            checks++;
            if (out_upd !== (16'h1 << k) || o[k] !== 32'h0) begin
                errors++;
                $display("FAIL clear_step%0d got upd=%h out=%h want upd=%h out=0",
                         k, out_upd, o[k], 16'h1 << k);
            end
            if (k == 4) begin
                checks++;
                if (o[7] !== 32'h107) begin
                    errors++;
                    $display("FAIL clear_write_blocked got %h want 00000107", o[7]);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || wif.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_exit got busy=%b rdy=%b want 0/1", busy, wif.wr_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0 || out_upd !== 16'h0) begin
            errors++;
            $display("FAIL clear_no_restart got busy=%b upd=%h want 0/0000", busy, out_upd);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (o[i] !== 32'h0) begin
                errors++;
                $display("FAIL clear_out%0d got %h want 00000000", i, o[i]);
            end
        end
    endtask

    task automatic test_clr_priority();
        wif.sel      = 4'd3;
        wif.din      = 32'h33;
        wif.wr_valid = 1'b1;
        step();
        wif.din     = 32'h55;
        wif.clr_all = 1'b1;
        step();
        wif.wr_valid = 1'b0;
        wif.clr_all  = 1'b0;
        checks++;
        if (busy !== 1'b1 || o[3] !== 32'h33 || out_upd !== 16'h0) begin
            errors++;
            $display("FAIL prio_drop got busy=%b out3=%h upd=%h want 1/00000033/0000",
                     busy, o[3], out_upd);
        end
        for (int k = 0; k < 16; k++) step();
        checks++;
        if (busy !== 1'b0 || o[3] !== 32'h0) begin
            errors++;
            $display("FAIL prio_done got busy=%b out3=%h want 0/00000000", busy, o[3]);
        end
    endtask

    task automatic test_rst_abort();
        wif.sel      = 4'd9;
        wif.din      = 32'h99;
        wif.wr_valid = 1'b1;
        step();
        wif.sel = 4'd12;
        wif.din = 32'hC;
        step();
        wif.wr_valid = 1'b0;
        wif.clr_all  = 1'b1;
        step();
        wif.clr_all = 1'b0;
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (busy !== 1'b1 || o[9] !== 32'h99 || o[12] !== 32'hC) begin
            errors++;
            $display("FAIL abort_pre got busy=%b out9=%h out12=%h want 1/00000099/0000000c",
                     busy, o[9], o[12]);
        end
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || out_upd !== 16'h0 || wif.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst got busy=%b upd=%h rdy=%b want 0/0000/0",
                     busy, out_upd, wif.wr_ready);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (o[i] !== 32'h0) begin
                errors++;
                $display("FAIL abort_out%0d got %h want 00000000", i, o[i]);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (wif.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_release got rdy=%b want 1", wif.wr_ready);
        end
        wif.sel      = 4'd15;
        wif.din      = 32'hF00D;
        wif.wr_valid = 1'b1;
        step();
        wif.wr_valid = 1'b0;
        checks++;
        if (o[15] !== 32'hF00D || out_upd !== 16'h8000) begin
            errors++;
            $display("FAIL abort_write got out15=%h upd=%h want 0000f00d/8000", o[15], out_upd);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        wif.sel      = '0;
        wif.din      = '0;
        wif.wr_valid = 1'b0;
        wif.clr_all  = 1'b0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_clear();
        test_clr_priority();
        test_rst_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
